// File: rtl/bus_gate_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_gate_arbiter_if
//  Description : Request/release/gate-select bundle between the four LC-3 bus
//                drivers and the bus gate arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_gate_arbiter_if;
    logic [3:0] req;       // [3]=PC [2]=Adder [1]=ALU [0]=MDR, level requests
    logic [3:0] done;      // release strobes, same bit order
    logic [3:0] gate;      // one-hot (or zero) gate select to the bus mux
    logic [1:0] owner;     // index of the most recent grantee
    logic       bus_idle;  // high whenever no driver is gated
    logic       preempt;   // pulses in the turnaround after a forced release

    // Arbiter side
    modport master (
        input  req,
        input  done,
        output gate,
        output owner,
        output bus_idle,
        output preempt
    );

    // Bus-driver side
    modport slave (
        output req,
        output done,
        input  gate,
        input  owner,
        input  bus_idle,
        input  preempt
    );
endinterface
`default_nettype wire

// File: rtl/bus_gate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_gate_arbiter
//  Description : Round-robin arbiter for the shared 16-bit datapath bus.
//                Grants one driver at a time with a bounded tenure and
//                inserts one dead cycle between any two grants.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_gate_arbiter #(
    parameter int HOLD_MAX = 4   // tenure limit before preemption, 1..15
) (
    input  wire logic          clk,
    input  wire logic          rst,
    bus_gate_arbiter_if.master bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_TURN  = 2'd2;
    localparam logic [3:0] c_HOLD  = 4'(HOLD_MAX);

    // Registered state. owner_q doubles as the "last granted" pointer that
    // anchors the round-robin search, since both are updated on every grant.
    logic [1:0] state_q,    state_d;
    logic [3:0] gate_q,     gate_d;
    logic [1:0] owner_q,    owner_d;
    logic [3:0] cnt_q,      cnt_d;
    logic       preempt_q,  preempt_d;
    logic       bus_idle_q, bus_idle_d;

    logic [1:0] w_win_idx;
    logic       w_win_any;
    logic [3:0] w_owner_oh;
    logic       w_rel_a;
    logic       w_others;
    logic       w_rel_b;

    // Round-robin winner: search from owner-1 downward with wrap, owner last
    always_comb begin
        logic [1:0] idx;
        idx       = '0;
        w_win_idx = owner_q;
        w_win_any = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = owner_q - 2'(i);
            if (!w_win_any && bus.req[idx]) begin
                w_win_any = 1'b1;
                w_win_idx = idx;
            end
        end
    end

    // Release conditions for the current owner while it holds the bus
    always_comb begin
        w_owner_oh = 4'b0001 << owner_q;
        w_rel_a    = bus.done[owner_q] | ~bus.req[owner_q];
        w_others   = |(bus.req & ~w_owner_oh);
        w_rel_b    = (cnt_q == c_HOLD) && w_others && !w_rel_a;
    end

    // Next-state logic for the IDLE / GRANT / TURN sequencer
    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;

        case (state_q)
            c_IDLE, c_TURN: begin
                // Gate is always low here; a grant is issued only from these
                // states, which is what guarantees the dead cycle.
                gate_d = '0;
                cnt_d  = '0;
                if (w_win_any) begin
                    state_d = c_GRANT;
                    owner_d = w_win_idx;
                    gate_d  = 4'b0001 << w_win_idx;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = c_IDLE;
                end
            end

            c_GRANT: begin
                if (w_rel_a || w_rel_b) begin
                    state_d   = c_TURN;
                    gate_d    = '0;
                    cnt_d     = '0;
                    preempt_d = w_rel_b;
                end else if (cnt_q != c_HOLD) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = c_IDLE;
                gate_d  = '0;
                cnt_d   = '0;
            end
        endcase

        bus_idle_d = ~|gate_d;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            gate_q     <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            preempt_q  <= 1'b0;
            bus_idle_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            preempt_q  <= preempt_d;
            bus_idle_q <= bus_idle_d;
        end
    end

    assign bus.gate     = gate_q;
    assign bus.owner    = owner_q;
    assign bus.bus_idle = bus_idle_q;
    assign bus.preempt  = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_gate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_gate_arbiter
//  Description : Directed and randomized checks for bus_gate_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_gate_arbiter;

    localparam int c_HOLD = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bus_gate_arbiter_if bus_if ();

    bus_gate_arbiter #(.HOLD_MAX(c_HOLD)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus_if.req  = '0;
        bus_if.done = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_gate;
        logic [3:0] applied;
        logic [3:0] prev_gate;
        logic [1:0] prev_owner;
        logic       prev_pre;
        int         wait_cnt [4];
        int         max_wait;
        int         v_onehot, v_trans, v_pre, v_own;

        total = 0;
        bad   = 0;

        // ---- post-reset priority with all four requesting ----
        rst         = 1'b1;
        bus_if.req  = '0;
        bus_if.done = '0;
        tick();
        tick();
        check("rst_gate",    32'(bus_if.gate),     32'h0);
        check("rst_owner",   32'(bus_if.owner),    32'h0);
        check("rst_idle",    32'(bus_if.bus_idle), 32'h1);
        check("rst_preempt", 32'(bus_if.preempt),  32'h0);
        rst        = 1'b0;
        bus_if.req = 4'b1111;
        tick();
        for (int g = 0; g < 4; g++) begin
            exp_gate = 4'b1000 >> g;
            check("pri_owner", 32'(bus_if.owner), 32'(3 - g));
            for (int c = 0; c < c_HOLD; c++) begin
                check("pri_gate", 32'(bus_if.gate), 32'(exp_gate));
                check("pri_nopre", 32'(bus_if.preempt), 32'h0);
                tick();
            end
            check("pri_turn_gate", 32'(bus_if.gate),     32'h0);
            check("pri_turn_pre",  32'(bus_if.preempt),  32'h1);
            check("pri_turn_idle", 32'(bus_if.bus_idle), 32'h1);
            tick();
        end
        check("pri_wrap_gate",  32'(bus_if.gate),  32'h8);
        check("pri_wrap_owner", 32'(bus_if.owner), 32'h3);

        // ---- single requester keeps the bus ----
        do_reset();
        bus_if.req = 4'b0010;
        tick();
        check("solo_owner", 32'(bus_if.owner), 32'h1);
        for (int c = 0; c < 20; c++) begin
            check("solo_gate", 32'(bus_if.gate),    32'h2);
            check("solo_pre",  32'(bus_if.preempt), 32'h0);
            tick();
        end
        bus_if.req = '0;
        tick();
        check("solo_drop_gate", 32'(bus_if.gate), 32'h0);
        tick();
        check("solo_idle",      32'(bus_if.bus_idle), 32'h1);
        check("solo_owner_hold", 32'(bus_if.owner),   32'h1);

        // ---- Done release in the third grant cycle ----
        do_reset();
        bus_if.req = 4'b0001;
        tick();
        check("done_g1", 32'(bus_if.gate), 32'h1);
        tick();
        tick();
        check("done_g3", 32'(bus_if.gate), 32'h1);
        bus_if.done = 4'b0001;
        tick();
        check("done_rel_gate", 32'(bus_if.gate),     32'h0);
        check("done_rel_pre",  32'(bus_if.preempt),  32'h0);
        check("done_rel_idle", 32'(bus_if.bus_idle), 32'h1);
        bus_if.done = '0;
        bus_if.req  = '0;
        tick();
        check("done_idle_gate", 32'(bus_if.gate),     32'h0);
        check("done_idle",      32'(bus_if.bus_idle), 32'h1);

        // ---- minimum tenure: Done in the first grant cycle ----
        bus_if.req = 4'b0100;
        tick();
        check("min_gate",  32'(bus_if.gate),  32'h4);
        check("min_owner", 32'(bus_if.owner), 32'h2);
        bus_if.done = 4'b0100;
        tick();
        check("min_rel", 32'(bus_if.gate), 32'h0);
        bus_if.done = '0;
        tick();
        check("min_regrant", 32'(bus_if.gate), 32'h4);
        bus_if.req = '0;
        tick();
        tick();

        // ---- Done bits of non-owners are ignored ----
        do_reset();
        bus_if.req = 4'b0010;
        tick();
        bus_if.done = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("ign_gate", 32'(bus_if.gate), 32'h2);
        end
        bus_if.done = '0;

        // ---- preemption where the next winner is the lowest-priority source ----
        do_reset();
        bus_if.req = 4'b1001;
        tick();
        for (int c = 0; c < c_HOLD; c++) tick();
        check("pre2_turn", 32'(bus_if.preempt), 32'h1);
        tick();
        check("pre2_next", 32'(bus_if.gate), 32'h1);
        check("pre2_pulse_once", 32'(bus_if.preempt), 32'h0);

        // ---- reset during a PC grant ----
        do_reset();
        bus_if.req = 4'b1000;
        tick();
        tick();
        check("mid_pre_gate", 32'(bus_if.gate), 32'h8);
        rst        = 1'b1;
        bus_if.req = 4'b0101;
        tick();
        check("mid_gate",  32'(bus_if.gate),     32'h0);
        check("mid_owner", 32'(bus_if.owner),    32'h0);
        check("mid_idle",  32'(bus_if.bus_idle), 32'h1);
        check("mid_pre",   32'(bus_if.preempt),  32'h0);
        rst = 1'b0;
        tick();
        check("mid_after_gate",  32'(bus_if.gate),  32'h4);
        check("mid_after_owner", 32'(bus_if.owner), 32'h2);

        // ---- randomized invariants ----
        do_reset();
        prev_gate  = bus_if.gate;
        prev_owner = bus_if.owner;
        prev_pre   = bus_if.preempt;
        max_wait   = 0;
        v_onehot   = 0;
        v_trans    = 0;
        v_pre      = 0;
        v_own      = 0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) bus_if.req[i] = ~bus_if.req[i];
                bus_if.done[i] = ($urandom_range(7) == 0);
            end
            applied = bus_if.req;
            tick();
            if ($countones(bus_if.gate) > 1) v_onehot++;
            if (bus_if.gate != 4'h0 && prev_gate != 4'h0 && bus_if.gate != prev_gate) v_trans++;
            if (bus_if.preempt && (bus_if.gate != 4'h0 || prev_pre)) v_pre++;
            if (bus_if.gate == 4'h0 && bus_if.owner != prev_owner) v_own++;
            if (bus_if.gate != 4'h0 && bus_if.gate != (4'b0001 << bus_if.owner)) v_own++;
            if (bus_if.bus_idle != (bus_if.gate == 4'h0)) v_own++;
            for (int i = 0; i < 4; i++) begin
                if (applied[i] && !bus_if.gate[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            prev_gate  = bus_if.gate;
            prev_owner = bus_if.owner;
            prev_pre   = bus_if.preempt;
        end
        check("rnd_onehot",   32'(v_onehot), 32'h0);
        check("rnd_deadcyc",  32'(v_trans),  32'h0);
        check("rnd_preempt",  32'(v_pre),    32'h0);
        check("rnd_owner",    32'(v_own),    32'h0);
        check("rnd_wait_ok",  32'(max_wait <= 4 * (c_HOLD + 1)), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
